// File: rtl/mem_stage.sv
// Memory stage: ALU writeback pass-through and a fixed-latency data memory.
// Optional MEM_ALIGN_CHK_EN flags odd byte addresses and suppresses their effect.
module mem_stage #(
    parameter int MEM_LAT = 2,
    parameter int MEM_AW  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ldst_valid_ixmem_p1,
    input  logic        ld_ixmem_p1,
    input  logic        alu_valid_ixmem_p1,
    input  logic [15:0] addr_ixmem_p1,
    input  logic [15:0] data_ixmem_p1,
    input  logic [2:0]  rd_ixmem_p1,
    input  logic [25:0] uop_cnt_ixmem_p1,
    output logic        mem_stall_p1,
    output logic        wb_valid_memwb_p1,
    output logic [2:0]  wb_rd_memwb_p1,
    output logic [15:0] wb_data_memwb_p1,
    output logic        retire_valid_p1,
    output logic [25:0] uop_cnt_memwb_p1,
    output logic        err_mem_p1
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam bit         LAT1   = (MEM_LAT == 1);
    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    state_t              r_state;
    logic [1:0]          r_cnt;
    logic                r_ld;
    logic [MEM_AW-1:0]   r_idx;
    logic [15:0]         r_data;
    logic [2:0]          r_rd;
    logic [25:0]         r_tag;
    logic                r_wb_valid;
    logic                r_retire;
    logic [2:0]          r_wb_rd;
    logic [15:0]         r_wb_data;
    logic [25:0]         r_uop;
    logic [15:0]         r_mem [0:(2**MEM_AW)-1];

    logic                w_idle;
    logic                w_acc_ls;
    logic                w_acc_alu;
    logic                w_done;
    logic                w_op_ld;
    logic [MEM_AW-1:0]   w_op_idx;
    logic [15:0]         w_op_data;
    logic [2:0]          w_op_rd;
    logic [25:0]         w_op_tag;
    logic                w_bad;
    logic                w_we;
    logic                w_unused;

    assign w_idle    = (r_state == IDLE);
    assign w_acc_ls  = w_idle & ldst_valid_ixmem_p1;
    assign w_acc_alu = w_idle & ~ldst_valid_ixmem_p1 & alu_valid_ixmem_p1;

    // With single-cycle latency the op completes on its accept edge,
    // so the live inputs stand in for the latched copy.
    assign w_done    = LAT1 ? w_acc_ls : ((r_state == BUSY) && (r_cnt == 2'd1));
    assign w_op_ld   = LAT1 ? ld_ixmem_p1 : r_ld;
    assign w_op_idx  = LAT1 ? addr_ixmem_p1[MEM_AW:1] : r_idx;
    assign w_op_data = LAT1 ? data_ixmem_p1 : r_data;
    assign w_op_rd   = LAT1 ? rd_ixmem_p1 : r_rd;
    assign w_op_tag  = LAT1 ? uop_cnt_ixmem_p1 : r_tag;

    assign w_unused  = ^{addr_ixmem_p1[15:MEM_AW+1], addr_ixmem_p1[0]};

`ifdef MEM_ALIGN_CHK_EN
    logic r_a0;
    logic r_err;
    assign w_bad      = LAT1 ? addr_ixmem_p1[0] : r_a0;
    assign err_mem_p1 = r_err;

    // Sticky misalignment flag, raised when the odd address is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a0  <= 1'b0;
            r_err <= 1'b0;
        end else if (w_acc_ls) begin
            r_a0 <= addr_ixmem_p1[0];
            if (addr_ixmem_p1[0]) r_err <= 1'b1;
        end
    end
`else
    assign w_bad      = 1'b0;
    assign err_mem_p1 = 1'b0;
`endif

    // Reset gates the write so an op aborted in BUSY never lands.
    assign w_we = rst & w_done & ~w_op_ld & ~w_bad;

    assign mem_stall_p1      = (r_state == BUSY);
    assign wb_valid_memwb_p1 = r_wb_valid;
    assign wb_rd_memwb_p1    = r_wb_rd;
    assign wb_data_memwb_p1  = r_wb_data;
    assign retire_valid_p1   = r_retire;
    assign uop_cnt_memwb_p1  = r_uop;

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_op_idx] <= w_op_data;
    end

    // Accept/latency FSM with registered writeback and retire outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= 2'd0;
            r_ld       <= 1'b0;
            r_idx      <= '0;
            r_data     <= 16'd0;
            r_rd       <= 3'd0;
            r_tag      <= 26'd0;
            r_wb_valid <= 1'b0;
            r_retire   <= 1'b0;
            r_wb_rd    <= 3'd0;
            r_wb_data  <= 16'd0;
            r_uop      <= 26'd0;
        end else begin
            r_wb_valid <= 1'b0;
            r_retire   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc_ls) begin
                        r_ld   <= ld_ixmem_p1;
                        r_idx  <= addr_ixmem_p1[MEM_AW:1];
                        r_data <= data_ixmem_p1;
                        r_rd   <= rd_ixmem_p1;
                        r_tag  <= uop_cnt_ixmem_p1;
                        r_cnt  <= LAT_M1;
                        if (!LAT1) r_state <= BUSY;
                    end else if (w_acc_alu) begin
                        r_wb_valid <= 1'b1;
                        r_retire   <= 1'b1;
                        r_wb_rd    <= rd_ixmem_p1;
                        r_wb_data  <= data_ixmem_p1;
                        r_uop      <= uop_cnt_ixmem_p1;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
            if (w_done) begin
                r_retire <= 1'b1;
                r_uop    <= w_op_tag;
                if (w_op_ld && !w_bad) begin
                    r_wb_valid <= 1'b1;
                    r_wb_rd    <= w_op_rd;
                    r_wb_data  <= r_mem[w_op_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: MEM_LAT=2 vector table, reset abort,
// alignment behaviour, and a MEM_LAT=1 back-to-back instance.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        ldv, ld, aluv;
    logic [15:0] addr, data;
    logic [2:0]  rd;
    logic [25:0] tag;
    logic        stall, wbv, ret, err;
    logic [2:0]  wbrd;
    logic [15:0] wbdata;
    logic [25:0] uop;

    logic        s_ldv, s_ld, s_aluv;
    logic [15:0] s_addr, s_data;
    logic [2:0]  s_rd;
    logic [25:0] s_tag;
    logic        s_stall, s_wbv, s_ret, s_err;
    logic [2:0]  s_wbrd;
    logic [15:0] s_wbdata;
    logic [25:0] s_uop;

    mem_stage u_dut (
        .clk(clk), .rst(rst),
        .ldst_valid_ixmem_p1(ldv), .ld_ixmem_p1(ld),
        .alu_valid_ixmem_p1(aluv), .addr_ixmem_p1(addr),
        .data_ixmem_p1(data), .rd_ixmem_p1(rd),
        .uop_cnt_ixmem_p1(tag), .mem_stall_p1(stall),
        .wb_valid_memwb_p1(wbv), .wb_rd_memwb_p1(wbrd),
        .wb_data_memwb_p1(wbdata), .retire_valid_p1(ret),
        .uop_cnt_memwb_p1(uop), .err_mem_p1(err)
    );

    mem_stage #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .ldst_valid_ixmem_p1(s_ldv), .ld_ixmem_p1(s_ld),
        .alu_valid_ixmem_p1(s_aluv), .addr_ixmem_p1(s_addr),
        .data_ixmem_p1(s_data), .rd_ixmem_p1(s_rd),
        .uop_cnt_ixmem_p1(s_tag), .mem_stall_p1(s_stall),
        .wb_valid_memwb_p1(s_wbv), .wb_rd_memwb_p1(s_wbrd),
        .wb_data_memwb_p1(s_wbdata), .retire_valid_p1(s_ret),
        .uop_cnt_memwb_p1(s_uop), .err_mem_p1(s_err)
    );

`ifdef MEM_ALIGN_CHK_EN
    localparam logic ALN = 1'b1;
`else
    localparam logic ALN = 1'b0;
`endif

    typedef struct {
        logic        ldv, ld, aluv;
        logic [15:0] addr, data;
        logic [2:0]  rd;
        logic [25:0] tag;
        logic        ewv, eret, est;
        logic [2:0]  erd;
        logic [15:0] edata;
        logic [25:0] etag;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    wire [48:0] obs  = {wbv, ret, stall, err, wbrd, wbdata, uop};
    wire [48:0] obs1 = {s_wbv, s_ret, s_stall, s_err, s_wbrd, s_wbdata, s_uop};

    function automatic logic [48:0] pk(input logic wv, input logic rt,
        input logic st, input logic er, input logic [2:0] r,
        input logic [15:0] d, input logic [25:0] t);
        return {wv, rt, st, er, r, d, t};
    endfunction

    function automatic vec_t mk(input logic lv, input logic l, input logic av,
        input logic [15:0] a, input logic [15:0] d, input logic [2:0] r,
        input logic [25:0] t, input logic ewv, input logic eret,
        input logic est, input logic [2:0] erd, input logic [15:0] ed,
        input logic [25:0] et);
        vec_t v;
        v.ldv = lv; v.ld = l; v.aluv = av; v.addr = a; v.data = d;
        v.rd = r; v.tag = t; v.ewv = ewv; v.eret = eret; v.est = est;
        v.erd = erd; v.edata = ed; v.etag = et;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drv(input logic lv, input logic l, input logic av,
        input logic [15:0] a, input logic [15:0] d, input logic [2:0] r,
        input logic [25:0] t);
        ldv = lv; ld = l; aluv = av; addr = a; data = d; rd = r; tag = t;
    endtask

    task automatic drv1(input logic lv, input logic l,
        input logic [15:0] a, input logic [15:0] d, input logic [2:0] r,
        input logic [25:0] t);
        s_ldv = lv; s_ld = l; s_aluv = 1'b0; s_addr = a; s_data = d;
        s_rd = r; s_tag = t;
    endtask

    vec_t tbl [14];
    logic [15:0] ops_a [6];
    logic [15:0] ops_d [6];
    logic        ops_l [6];
    logic [25:0] ops_t [6];

    initial begin
        drv(0, 0, 0, 0, 0, 0, 0);
        drv1(0, 0, 0, 0, 0, 0);

        //     ldv ld alu addr     data     rd tag | wv rt st rd data     tag
        tbl[0]  = mk(1, 0, 0, 16'h0010, 16'hBEEF, 0, 5,  0, 0, 0, 0, 16'h0000, 0);
        tbl[1]  = mk(1, 0, 0, 16'h0010, 16'hBEEF, 0, 5,  0, 0, 1, 0, 16'h0000, 0);
        tbl[2]  = mk(1, 1, 0, 16'h0010, 16'h0000, 3, 6,  0, 1, 0, 0, 16'h0000, 5);
        tbl[3]  = mk(1, 1, 0, 16'h0010, 16'h0000, 3, 6,  0, 0, 1, 0, 16'h0000, 5);
        tbl[4]  = mk(0, 0, 1, 16'h0000, 16'h1234, 7, 7,  1, 1, 0, 3, 16'hBEEF, 6);
        tbl[5]  = mk(1, 1, 1, 16'h0010, 16'h5555, 2, 8,  1, 1, 0, 7, 16'h1234, 7);
        tbl[6]  = mk(1, 1, 1, 16'h0010, 16'h5555, 2, 8,  0, 0, 1, 7, 16'h1234, 7);
        tbl[7]  = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0,  1, 1, 0, 2, 16'hBEEF, 8);
        tbl[8]  = mk(1, 0, 0, 16'h0810, 16'hCAFE, 0, 10, 0, 0, 0, 2, 16'hBEEF, 8);
        tbl[9]  = mk(1, 0, 0, 16'h0810, 16'hCAFE, 0, 10, 0, 0, 1, 2, 16'hBEEF, 8);
        tbl[10] = mk(1, 1, 0, 16'h0010, 16'h0000, 1, 11, 0, 1, 0, 2, 16'hBEEF, 10);
        tbl[11] = mk(1, 1, 0, 16'h0010, 16'h0000, 1, 11, 0, 0, 1, 2, 16'hBEEF, 10);
        tbl[12] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0,  1, 1, 0, 1, 16'hCAFE, 11);
        tbl[13] = mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0,  0, 0, 0, 1, 16'hCAFE, 11);

        // Reset state of both instances.
        repeat (2) @(negedge clk);
        chk("reset_lat2", 64'(obs), 64'(pk(0, 0, 0, 0, 0, 0, 0)));
        chk("reset_lat1", 64'(obs1), 64'(pk(0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;

        // Main vector table on the MEM_LAT=2 instance.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d", i), 64'(obs),
                64'(pk(tbl[i].ewv, tbl[i].eret, tbl[i].est, 0,
                       tbl[i].erd, tbl[i].edata, tbl[i].etag)));
            drv(tbl[i].ldv, tbl[i].ld, tbl[i].aluv, tbl[i].addr,
                tbl[i].data, tbl[i].rd, tbl[i].tag);
        end

        // Known value at 0x0020, then a store aborted by reset.
        @(negedge clk); drv(1, 0, 0, 16'h0020, 16'h1111, 0, 30);
        @(negedge clk);
        @(negedge clk);
        chk("seed_retire", 64'({ret, wbv, uop}), 64'({1'b1, 1'b0, 26'd30}));
        drv(1, 0, 0, 16'h0020, 16'hAAAA, 0, 31);
        @(negedge clk);
        chk("abort_busy", 64'(stall), 64'(1'b1));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rst0", 64'(obs), 64'(pk(0, 0, 0, 0, 0, 0, 0)));
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("abort_rst1", 64'(obs), 64'(pk(0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_noret", 64'(obs), 64'(pk(0, 0, 0, 0, 0, 0, 0)));
        drv(1, 1, 0, 16'h0020, 16'h0000, 4, 32);
        @(negedge clk);
        @(negedge clk);
        chk("abort_load", 64'(obs), 64'(pk(1, 1, 0, 0, 4, 16'h1111, 32)));

        // Odd-address store.
        drv(1, 0, 0, 16'h0021, 16'h5A5A, 0, 40);
        @(negedge clk);
        chk("odd_busy", 64'(stall), 64'(1'b1));
        @(negedge clk);
        chk("odd_retire", 64'(obs), 64'(pk(0, 1, 0, ALN, 4, 16'h1111, 40)));
        drv(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("odd_sticky", 64'(obs), 64'(pk(0, 0, 0, ALN, 4, 16'h1111, 40)));
        drv(1, 1, 0, 16'h0020, 16'h0000, 5, 41);
        @(negedge clk);
        @(negedge clk);
        chk("odd_load", 64'(obs),
            64'(pk(1, 1, 0, ALN, 5, ALN ? 16'h1111 : 16'h5A5A, 41)));
        drv(0, 0, 0, 0, 0, 0, 0);

        // MEM_LAT=1: store, dependent load, then four back-to-back loads.
        ops_l[0] = 0; ops_a[0] = 16'h0030; ops_d[0] = 16'h7777; ops_t[0] = 50;
        ops_l[1] = 1; ops_a[1] = 16'h0030; ops_d[1] = 16'h0000; ops_t[1] = 51;
        ops_l[2] = 1; ops_a[2] = 16'h0032; ops_d[2] = 16'h0000; ops_t[2] = 1;
        ops_l[3] = 1; ops_a[3] = 16'h0034; ops_d[3] = 16'h0000; ops_t[3] = 2;
        ops_l[4] = 1; ops_a[4] = 16'h0036; ops_d[4] = 16'h0000; ops_t[4] = 3;
        ops_l[5] = 1; ops_a[5] = 16'h0030; ops_d[5] = 16'h0000; ops_t[5] = 4;
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("lat1_op%0d", i - 1),
                    64'({s_wbv, s_ret, s_stall, s_uop}),
                    64'({ops_l[i-1], 1'b1, 1'b0, ops_t[i-1]}));
                if (ops_l[i-1] && ops_a[i-1] == 16'h0030)
                    chk($sformatf("lat1_data%0d", i - 1),
                        64'({s_wbrd, s_wbdata}),
                        64'({3'(i - 1), 16'h7777}));
            end
            if (i < 6) drv1(1, ops_l[i], ops_a[i], ops_d[i], 3'(i), ops_t[i]);
            else       drv1(0, 0, 0, 0, 0, 0);
        end
        @(negedge clk);
        chk("lat1_quiet", 64'({s_ret, s_wbv, s_stall}), 64'(3'b000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
